// File: rtl/openhw_skidbuf_pkg.sv
// Shared types and default parameters for the openhw_skidbuf register slice.
package openhw_skidbuf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skidbuf_state_t;

  localparam int SKIDBUF_WIDTH_DEF = 32;
  localparam int SKIDBUF_CNTW_DEF  = 16;

endpackage

// File: rtl/openhw_flopen.sv
// Plain enable flop bank, no reset; used for the main and skid data registers.
module openhw_flopen
  import openhw_skidbuf_pkg::*;
#(
  parameter int WIDTH = SKIDBUF_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/openhw_skidbuf.sv
// Two-entry valid/ready register slice with full throughput and registered handshakes.
// Optional stall counter enabled by defining OPENHW_SKIDBUF_STATS_EN.
//
//   state | meaning
//   EMPTY | nothing held; OutValid=0, InReady=1
//   BUSY  | main register valid; OutValid=1, InReady=1
//   FULL  | main and skid registers valid; OutValid=1, InReady=0
module openhw_skidbuf
  import openhw_skidbuf_pkg::*;
#(
  parameter int WIDTH = SKIDBUF_WIDTH_DEF,
  parameter int CNTW  = SKIDBUF_CNTW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [CNTW-1:0]  StallCount
);

  skidbuf_state_t state_q, state_d;
  logic             in_xfer, out_xfer;
  logic             main_en, main_sel_skid, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign OutValid = (state_q != EMPTY);
  assign InReady  = (state_q != FULL);
  assign in_xfer  = InValid & InReady;
  assign out_xfer = OutValid & OutReady;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    main_sel_skid = 1'b0;
    skid_en       = 1'b0;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = BUSY;
            main_en = 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_en = 1'b1;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_en = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // Skid entry is older than anything the producer can offer now.
          if (out_xfer) begin
            state_d       = BUSY;
            main_en       = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = main_sel_skid ? skid_q : InData;

  openhw_flopen #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .en  (main_en),
    .d   (main_d),
    .q   (OutData)
  );

  openhw_flopen #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .en  (skid_en),
    .d   (InData),
    .q   (skid_q)
  );

`ifdef OPENHW_SKIDBUF_STATS_EN
  logic [CNTW-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || Flush)
      stall_cnt_q <= '0;
    else if (OutValid && !OutReady && (stall_cnt_q != {CNTW{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign StallCount = stall_cnt_q;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_openhw_skidbuf.sv
// Self-checking bench for openhw_skidbuf: directed vector table plus multi-cycle sequences.
module tb_openhw_skidbuf;

  logic        clk = 1'b0;
  logic        reset, Flush, InValid, OutReady;
  logic        InReady, OutValid;
  logic [31:0] InData, OutData;
  logic [3:0]  StallCount;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  openhw_skidbuf #(.WIDTH(32), .CNTW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Flush      (Flush),
    .InValid    (InValid),
    .InReady    (InReady),
    .InData     (InData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutData    (OutData),
    .StallCount (StallCount)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic        chk_od;
    logic [31:0] e_od;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic flush, input logic iv,
                              input logic [31:0] id, input logic ordy, input logic e_ov,
                              input logic e_ir, input logic chk_od, input logic [31:0] e_od);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.chk_od = chk_od; v.e_od = e_od;
    return v;
  endfunction

  function automatic logic [31:0] stall_exp(input int n);
`ifdef OPENHW_SKIDBUF_STATS_EN
    return (n > 15) ? 32'd15 : 32'(n);
`else
    return 32'd0 + 32'(n & 0);
`endif
  endfunction

  int occ, in_idx, out_idx;
  logic in_x, out_x;

  initial begin
    //              rst flush iv  data   ordy ov ir chk od
    vecs[0]  = mk(0, 0, 1, 32'hA,  0, 1, 1, 1, 32'hA);
    vecs[1]  = mk(0, 0, 1, 32'hB,  0, 1, 0, 1, 32'hA);
    vecs[2]  = mk(0, 0, 1, 32'hC,  0, 1, 0, 1, 32'hA);
    vecs[3]  = mk(0, 0, 1, 32'hC,  1, 1, 1, 1, 32'hB);
    vecs[4]  = mk(0, 0, 1, 32'hC,  1, 1, 1, 1, 32'hC);
    vecs[5]  = mk(0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
    vecs[6]  = mk(0, 0, 1, 32'h5,  0, 1, 1, 1, 32'h5);
    vecs[7]  = mk(0, 0, 1, 32'h6,  0, 1, 0, 1, 32'h5);
    vecs[8]  = mk(0, 1, 1, 32'h7,  0, 0, 1, 0, 32'h0);
    vecs[9]  = mk(0, 0, 1, 32'h8,  1, 1, 1, 1, 32'h8);
    vecs[10] = mk(0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
    vecs[11] = mk(0, 0, 1, 32'h9,  0, 1, 1, 1, 32'h9);
    vecs[12] = mk(0, 1, 1, 32'h99, 0, 0, 1, 0, 32'h0);
    vecs[13] = mk(0, 0, 1, 32'h11, 0, 1, 1, 1, 32'h11);
    vecs[14] = mk(1, 0, 1, 32'h12, 0, 0, 1, 0, 32'h0);
    vecs[15] = mk(0, 0, 1, 32'h13, 1, 1, 1, 1, 32'h13);
    vecs[16] = mk(0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);

    reset = 1'b1; Flush = 1'b0; InValid = 1'b0; InData = '0; OutReady = 1'b0;
    step();
    step();
    chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
    chk("rst_inready", {31'b0, InReady}, 32'd1);
    chk("rst_stall", {28'b0, StallCount}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      reset = vecs[i].rst; Flush = vecs[i].flush; InValid = vecs[i].iv;
      InData = vecs[i].id; OutReady = vecs[i].ordy;
      step();
      chk($sformatf("vec%0d_outvalid", i), {31'b0, OutValid}, {31'b0, vecs[i].e_ov});
      chk($sformatf("vec%0d_inready", i), {31'b0, InReady}, {31'b0, vecs[i].e_ir});
      if (vecs[i].chk_od) chk($sformatf("vec%0d_outdata", i), OutData, vecs[i].e_od);
    end
    reset = 1'b0; Flush = 1'b0;

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      InValid = 1'b1; InData = 32'(i + 1); OutReady = 1'b1;
      step();
      chk($sformatf("stream%0d_data", i), OutData, 32'(i + 1));
      chk($sformatf("stream%0d_valid", i), {31'b0, OutValid}, 32'd1);
      chk($sformatf("stream%0d_ready", i), {31'b0, InReady}, 32'd1);
    end
    InValid = 1'b0;
    step();
    chk("stream_drain", {31'b0, OutValid}, 32'd0);

    // Alternating OutReady with a 16-value ramp; occupancy and order scoreboard.
    occ = 0; in_idx = 0; out_idx = 0;
    for (int c = 0; c < 100 && out_idx < 16; c++) begin
      InValid = (in_idx < 16); InData = 32'h100 + 32'(in_idx); OutReady = (c % 2 == 0);
      in_x = InValid & InReady;
      out_x = OutValid & OutReady;
      if (out_x) begin
        chk($sformatf("alt_data%0d", out_idx), OutData, 32'h100 + 32'(out_idx));
        out_idx++;
      end
      if (in_x) in_idx++;
      occ = occ + int'(in_x) - int'(out_x);
      step();
      chk($sformatf("alt_valid_c%0d", c), {31'b0, OutValid}, (occ != 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt_ready_c%0d", c), {31'b0, InReady}, (occ != 2) ? 32'd1 : 32'd0);
    end
    chk("alt_count", 32'(out_idx), 32'd16);
    InValid = 1'b0; OutReady = 1'b1;
    step();
    chk("alt_empty", {31'b0, OutValid}, 32'd0);

    // Stall counter: hold one entry with OutReady low.
    InValid = 1'b1; InData = 32'h55; OutReady = 1'b0;
    step();
    InValid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 5 || n == 15 || n == 20)
        chk($sformatf("stall_n%0d", n), {28'b0, StallCount}, stall_exp(n));
    end
    chk("stall_outdata", OutData, 32'h55);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("stall_flush_cnt", {28'b0, StallCount}, 32'd0);
    chk("stall_flush_valid", {31'b0, OutValid}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
